rids_merge_stream: RTL and testbench
====================================

# rids_merge_stream

Pipelined, back-pressured M-way merge tree for rule-ID sets (RIDS) in the packet-classification datapath. Each cycle it accepts M ascending RIDS (one per field lookup) plus a packet tag, and produces one ascending RIDS holding the NUM_RID smallest distinct RIDs of their union. It also reports the number of valid RIDs and an overflow flag. It replaces the free-running merge tree with a tree that has sentinel padding, duplicate removal, valid/ready flow control and per-packet tagging.

## Interface
- M, 8: number of input RIDS; power of two, ≥2
- LOG_M, 3: log2(M)
- RID_WIDTH, 8: bits per RID; all-ones value (2^RID_WIDTH−1) is reserved as EMPTY sentinel
- NUM_RID, 8: RID slots per RIDS; power of two, ≥2
- LOG_NUM_RID, 3: log2(NUM_RID)
- TAG_WIDTH, 8: packet tag width

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in  in  M·NUM_RID·RID_WIDTH  M RIDS, lane 0 at MSBs, slot 0 first within lane
- in_tag  in  TAG_WIDTH  packet tag, carried unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out  out  NUM_RID·RID_WIDTH  merged RIDS, ascending, EMPTY-padded at tail
- out_tag  out  TAG_WIDTH  tag of the beat on out
- out_cnt  out  LOG_NUM_RID+1  number of non-EMPTY slots in out
- out_ovf  out  1  union held more than NUM_RID distinct RIDs; some were dropped

## Operation
- Input contract: each lane is strictly ascending over non-EMPTY slots, and EMPTY slots only trail. An all-EMPTY lane is legal. Duplicates across lanes are legal.
- Tree: LOG_M stages. Stage s holds M/2^(s+1) merge nodes, each followed by a register slot carrying {RIDS, ovf, valid}. Tag and valid travel with node 0 of each stage.
- Merge node, inputs A and B:
  - With dedup compiled in: any B slot equal to a non-EMPTY A slot becomes EMPTY.
  - B is reversed, and the 2·NUM_RID-element bitonic sequence is merged ascending.
  - Lower NUM_RID elements go forward.
  - ovf_out = ovf_A | ovf_B | (any non-EMPTY element in the upper half).
- Stage-0 ovf inputs are 0.
- Flow control uses a per-stage elastic valid bit:
  - Stage s loads when its register is empty or stage s+1 loads this cycle.
  - The last stage's downstream advance is out_ready.
  - in_ready = stage-0 load condition, so bubbles collapse.
- Beat transfer: input on in_valid & in_ready; output on out_valid & out_ready.
- out_cnt is the popcount of non-EMPTY slots, computed combinationally from the last-stage register.
- EMPTY elements never count as overflow and never match in dedup.

## Timing
- Reset (reset_n low, async): all stage valid bits 0, so out_valid=0 and in_ready=1. out, out_tag and out_ovf reset to 0; out_cnt derives from out=0 and reads NUM_RID while out_valid=0. Consumers must qualify all outputs with out_valid.
- Latency: LOG_M cycles from input accept to out_valid with out_ready held high. Throughput is one beat per cycle.
- out_valid held with out_ready low: out, out_tag, out_cnt and out_ovf stay stable until the beat is accepted.
- A full pipe with out_ready low gives in_ready=0 combinationally in the same cycle. When out_ready rises, in_ready rises in that same cycle (no bubble).
- Simultaneous accept at input and output with a full pipe: every stage shifts and no beat is lost or duplicated.
- reset_n asserted mid-stream: all in-flight beats are discarded, with no partial output. After release, the first output comes LOG_M cycles after the first post-reset accept.
- in_ready does not depend on in_valid.

## Configuration
- MERGE_TREE_DEDUP_EN defined: cross-set equal RIDs are removed in every node. Output is distinct and out_cnt counts distinct RIDs.
- MERGE_TREE_DEDUP_EN undefined: no equality stage. Inputs must be globally distinct across lanes, or the output keeps duplicates, which count toward out_cnt and ovf. This saves NUM_RID² comparators per node.

## Test plan
All scenarios use M=4, NUM_RID=4, RID_WIDTH=4, EMPTY=15, DEDUP_EN defined.
- Disjoint sets: lanes {1,5,15,15}, {2,15,15,15}, {0,15,15,15}, {15,15,15,15}, tag 0xA5, out_ready=1 → 2 cycles later out={0,1,2,5}, cnt=4, ovf=0, tag=0xA5.
- Duplicates: lanes {3,7,15,15}, {3,7,15,15}, {7,9,15,15}, {3,15,15,15} → out={3,7,9,15}, cnt=3, ovf=0.
- Overflow: lanes {1,2,15,15}, {3,4,15,15}, {5,15,15,15}, {0,15,15,15} → out={0,1,2,3}, cnt=4, ovf=1.
- Back-pressure: stream 6 beats with tags 1..6, out_ready low cycles 3–7 → in_ready drops once 2 beats are held, all 6 tags emerge in order, and out is stable while stalled.
- Reset mid-stream: drop reset_n for 1 cycle with 2 beats in flight → out_valid=0 immediately, neither beat appears, and a new beat emerges 2 cycles after its accept.

Source files
------------

// File: rtl/rids_merge_stream.sv
// rids_merge_stream: pipelined, back-pressured M-way merge tree for rule-ID sets.
// Each accepted beat carries M ascending RIDS; the output is the NUM_RID smallest RIDs
// of their union, ascending and EMPTY-padded, with a valid count and an overflow flag.
// Optional feature: define MERGE_TREE_DEDUP_EN to remove cross-set duplicate RIDs in
// every merge node (default build: no dedup, inputs must be globally distinct).
module rids_merge_stream #(
    parameter int unsigned M           = 8,
    parameter int unsigned LOG_M       = 3,
    parameter int unsigned RID_WIDTH   = 8,
    parameter int unsigned NUM_RID     = 8,
    parameter int unsigned LOG_NUM_RID = 3,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [M*NUM_RID*RID_WIDTH-1:0]   in,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_RID*RID_WIDTH-1:0]     out,
    output logic [TAG_WIDTH-1:0]             out_tag,
    output logic [LOG_NUM_RID:0]             out_cnt,
    output logic                             out_ovf
);

    localparam int unsigned SW = NUM_RID * RID_WIDTH;
    localparam logic [RID_WIDTH-1:0] EMPTY = '1;
    localparam logic [LOG_NUM_RID:0] CNT_ONE = 1;

    // One merge node: returns {ovf_from_upper_half, lower NUM_RID elements}.
    // Slot 0 of a RIDS sits at the MSBs.
    function automatic logic [SW:0] merge_node(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [RID_WIDTH-1:0] e  [2*NUM_RID];
        logic [RID_WIDTH-1:0] bs [NUM_RID];
        logic [RID_WIDTH-1:0] tmp;
        logic [SW:0]          res;
        int                   st;
        int                   j;
`ifdef MERGE_TREE_DEDUP_EN
        logic [RID_WIDTH-1:0] bv   [NUM_RID];
        logic                 keep [NUM_RID];
        int                   rank [NUM_RID];
        int                   r;
`endif
        for (int i = 0; i < NUM_RID; i++) begin
            e[i]  = a[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH];
            bs[i] = EMPTY;
        end
`ifdef MERGE_TREE_DEDUP_EN
        // Drop B entries already present in A, then compact the survivors to the
        // front so B stays ascending and the concatenation stays bitonic.
        r = 0;
        for (int i = 0; i < NUM_RID; i++) begin
            bv[i]   = b[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH];
            keep[i] = (bv[i] != EMPTY);
            for (int k = 0; k < NUM_RID; k++) begin
                if (e[k] != EMPTY && e[k] == bv[i]) keep[i] = 1'b0;
            end
            rank[i] = r;
            if (keep[i]) r = r + 1;
        end
        for (int p = 0; p < NUM_RID; p++) begin
            for (int i = 0; i < NUM_RID; i++) begin
                if (keep[i] && rank[i] == p) bs[p] = bv[i];
            end
        end
`else
        for (int i = 0; i < NUM_RID; i++) begin
            bs[i] = b[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH];
        end
`endif
        // A ascending followed by B reversed forms a bitonic sequence.
        for (int i = 0; i < NUM_RID; i++) begin
            e[2*NUM_RID-1-i] = bs[i];
        end
        for (int l = 0; l <= LOG_NUM_RID; l++) begin
            st = NUM_RID >> l;
            for (int i = 0; i < 2*NUM_RID; i++) begin
                if ((i & st) == 0) begin
                    j = i + st;
                    if (e[i] > e[j]) begin
                        tmp  = e[i];
                        e[i] = e[j];
                        e[j] = tmp;
                    end
                end
            end
        end
        res = '0;
        for (int i = 0; i < NUM_RID; i++) begin
            res[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH] = e[i];
            if (e[NUM_RID+i] != EMPTY) res[SW] = 1'b1;
        end
        return res;
    endfunction

    genvar s, gi;
    for (s = 0; s < LOG_M; s++) begin : g_stage
        localparam int unsigned NODES = M >> (s + 1);

        logic [SW-1:0]        src_data [2*NODES];
        logic [2*NODES-1:0]   src_ovf;
        logic                 src_valid;
        logic [TAG_WIDTH-1:0] src_tag;
        logic                 adv;
        logic                 load;
        logic [SW:0]          node_res [NODES];

        logic                 q_valid;
        logic [TAG_WIDTH-1:0] q_tag;
        logic [SW-1:0]        q_data [NODES];
        logic [NODES-1:0]     q_ovf;

        if (s == 0) begin : g_src
            for (gi = 0; gi < 2*NODES; gi++) begin : g_lane
                assign src_data[gi] = in[(M-1-gi)*SW +: SW];
            end
            assign src_ovf   = '0;
            assign src_valid = in_valid;
            assign src_tag   = in_tag;
        end else begin : g_src
            for (gi = 0; gi < 2*NODES; gi++) begin : g_lane
                assign src_data[gi] = g_stage[s-1].q_data[gi];
            end
            assign src_ovf   = g_stage[s-1].q_ovf;
            assign src_valid = g_stage[s-1].q_valid;
            assign src_tag   = g_stage[s-1].q_tag;
        end

        if (s == LOG_M - 1) begin : g_adv
            assign adv = out_ready;
        end else begin : g_adv
            assign adv = g_stage[s+1].load;
        end

        // Elastic slot: refill when empty or when the downstream slot takes our beat.
        assign load = !q_valid || adv;

        for (gi = 0; gi < NODES; gi++) begin : g_node
            assign node_res[gi] = merge_node(src_data[2*gi], src_data[2*gi+1]);
        end

        // Stage register: captures merged sets, overflow, tag and valid on load.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q_valid <= 1'b0;
                q_tag   <= '0;
                q_ovf   <= '0;
                for (int i = 0; i < NODES; i++) q_data[i] <= '0;
            end else if (load) begin
                q_valid <= src_valid;
                q_tag   <= src_tag;
                for (int i = 0; i < NODES; i++) begin
                    q_data[i] <= node_res[i][SW-1:0];
                    q_ovf[i]  <= node_res[i][SW] | src_ovf[2*i] | src_ovf[2*i+1];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].load;
    assign out_valid = g_stage[LOG_M-1].q_valid;
    assign out       = g_stage[LOG_M-1].q_data[0];
    assign out_tag   = g_stage[LOG_M-1].q_tag;
    assign out_ovf   = g_stage[LOG_M-1].q_ovf[0];

    // Population count of non-EMPTY slots in the output set.
    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < NUM_RID; i++) begin
            if (out[i*RID_WIDTH +: RID_WIDTH] != EMPTY) out_cnt = out_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_rids_merge_stream.sv
// Bench for rids_merge_stream with M=4, NUM_RID=4, RID_WIDTH=4 (EMPTY=15).
// Follows MERGE_TREE_DEDUP_EN the same way the design does.
module tb_rids_merge_stream;

    localparam int M = 4;
    localparam int LOG_M = 2;
    localparam int RW = 4;
    localparam int N = 4;
    localparam int LOGN = 2;
    localparam int TW = 8;
    localparam int SW = N * RW;
`ifdef MERGE_TREE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [M*SW-1:0] in_bus;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_bus;
    logic [TW-1:0]   out_tag;
    logic [LOGN:0]   out_cnt;
    logic            out_ovf;

    rids_merge_stream #(
        .M(M), .LOG_M(LOG_M), .RID_WIDTH(RW), .NUM_RID(N), .LOG_NUM_RID(LOGN), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_bus),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out(out_bus),
        .out_tag(out_tag), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [SW-1:0] o;
        logic [TW-1:0] tag;
        logic [LOGN:0] cnt;
        logic          ovf;
        int            cyc;
    } beat_t;

    beat_t         exp_q[$];
    logic [TW-1:0] tag_log[$];

    function automatic logic [SW-1:0] lane(input int a, input int b, input int c, input int d);
        return {4'(a), 4'(b), 4'(c), 4'(d)};
    endfunction

    // Reference: union of all lanes (distinct if dedup), sorted, first N kept.
    function automatic beat_t model(input logic [M*SW-1:0] v, input logic [TW-1:0] tag);
        int    vals[$];
        int    x;
        bit    seen;
        beat_t b;
        for (int i = 0; i < M*N; i++) begin
            x = int'(v[(M*N-1-i)*RW +: RW]);
            if (x != 15) begin
                seen = 1'b0;
                foreach (vals[k]) if (vals[k] == x) seen = 1'b1;
                if (!(seen && DEDUP)) vals.push_back(x);
            end
        end
        vals.sort();
        b.o = '1;
        for (int k = 0; k < N; k++) begin
            if (k < vals.size()) b.o[(N-1-k)*RW +: RW] = 4'(vals[k]);
        end
        b.cnt = (vals.size() > N) ? 3'(N) : 3'(vals.size());
        b.ovf = (vals.size() > N);
        b.tag = tag;
        b.cyc = 0;
        return b;
    endfunction

    function automatic logic [M*SW-1:0] rand_beat();
        logic [M*SW-1:0] v;
        int cnt;
        int cur;
        v = '1;
        for (int l = 0; l < M; l++) begin
            cnt = $urandom_range(0, 4);
            cur = $urandom_range(0, 3);
            for (int k = 0; k < N; k++) begin
                if (k < cnt && cur <= 14) begin
                    v[(M-1-l)*SW + (N-1-k)*RW +: RW] = 4'(cur);
                    cur = cur + $urandom_range(1, 3);
                end
            end
        end
        return v;
    endfunction

    // Per-cycle compare against the reference queue.
    int            cyc = 0;
    logic          exp_valid;
    logic          held = 1'b0;
    logic [SW-1:0] h_out;
    logic [TW-1:0] h_tag;
    logic [LOGN:0] h_cnt;
    logic          h_ovf;
    beat_t         nb;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            held = 1'b0;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_in_ready", in_ready, 1);
        end else begin
            exp_valid = (exp_q.size() > 0) && (cyc - exp_q[0].cyc >= LOG_M);
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, (exp_q.size() < LOG_M) || out_ready);
            if (out_valid && exp_q.size() > 0) begin
                chk("out", out_bus, exp_q[0].o);
                chk("out_tag", out_tag, exp_q[0].tag);
                chk("out_cnt", out_cnt, exp_q[0].cnt);
                chk("out_ovf", out_ovf, exp_q[0].ovf);
            end
            if (held && out_valid) begin
                chk("stall_out", out_bus, h_out);
                chk("stall_tag", out_tag, h_tag);
                chk("stall_cnt", out_cnt, h_cnt);
                chk("stall_ovf", out_ovf, h_ovf);
            end
            held  = out_valid && !out_ready;
            h_out = out_bus;
            h_tag = out_tag;
            h_cnt = out_cnt;
            h_ovf = out_ovf;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                tag_log.push_back(out_tag);
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                nb = model(in_bus, in_tag);
                nb.cyc = cyc;
                exp_q.push_back(nb);
            end
        end
    end

    // Present one beat for one cycle (pipe assumed able to accept).
    task automatic send_one(input logic [M*SW-1:0] v, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_bus   = v;
        in_tag   = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    int sent;
    int n_low;
    bit need_new;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_bus    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_out", out_bus, 0);
        chk("init_tag", out_tag, 0);
        chk("init_ovf", out_ovf, 0);
        chk("init_cnt", out_cnt, 4);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Disjoint sets.
        send_one({lane(1, 5, 15, 15), lane(2, 15, 15, 15), lane(0, 15, 15, 15),
                  lane(15, 15, 15, 15)}, 8'hA5);
        @(negedge clk);
        chk("disj_latency", out_valid, 0);
        @(negedge clk);
        chk("disj_valid", out_valid, 1);
        chk("disj_out", out_bus, lane(0, 1, 2, 5));
        chk("disj_cnt", out_cnt, 4);
        chk("disj_ovf", out_ovf, 0);
        chk("disj_tag", out_tag, 8'hA5);
        @(posedge clk);
        #1;

        // Duplicate RIDs across lanes.
        send_one({lane(3, 7, 15, 15), lane(3, 7, 15, 15), lane(7, 9, 15, 15),
                  lane(3, 15, 15, 15)}, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        chk("dup_valid", out_valid, 1);
`ifdef MERGE_TREE_DEDUP_EN
        chk("dup_out", out_bus, lane(3, 7, 9, 15));
        chk("dup_cnt", out_cnt, 3);
        chk("dup_ovf", out_ovf, 0);
`else
        chk("dup_out", out_bus, lane(3, 3, 3, 7));
        chk("dup_cnt", out_cnt, 4);
        chk("dup_ovf", out_ovf, 1);
`endif
        @(posedge clk);
        #1;

        // Overflow: six distinct RIDs into four slots.
        send_one({lane(1, 2, 15, 15), lane(3, 4, 15, 15), lane(5, 15, 15, 15),
                  lane(0, 15, 15, 15)}, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_out", out_bus, lane(0, 1, 2, 3));
        chk("ovf_cnt", out_cnt, 4);
        chk("ovf_ovf", out_ovf, 1);
        @(posedge clk);
        #1;

        // Back-pressure: six beats, out_ready low in cycles 3..7.
        tag_log.delete();
        sent     = 0;
        n_low    = 0;
        need_new = 1'b1;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (sent < 6) begin
                in_valid = 1'b1;
                if (need_new) in_bus = rand_beat();
                in_tag = 8'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            need_new = 1'b0;
            if (in_valid && !in_ready) n_low++;
            if (in_valid && in_ready) begin
                sent++;
                need_new = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_in_ready_dropped", (n_low > 0), 1);
        chk("bp_sent", sent, 6);
        chk("bp_emitted", tag_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < tag_log.size()) chk("bp_tag_order", tag_log[k], k + 1);
        end

        // Reset with two beats in flight.
        tag_log.delete();
        send_one({lane(4, 15, 15, 15), lane(15, 15, 15, 15), lane(15, 15, 15, 15),
                  lane(15, 15, 15, 15)}, 8'h31);
        send_one({lane(6, 15, 15, 15), lane(15, 15, 15, 15), lane(15, 15, 15, 15),
                  lane(15, 15, 15, 15)}, 8'h32);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_one({lane(2, 8, 15, 15), lane(1, 15, 15, 15), lane(15, 15, 15, 15),
                  lane(9, 15, 15, 15)}, 8'h77);
        @(negedge clk);
        chk("post_rst_latency", out_valid, 0);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_tag", out_tag, 8'h77);
        chk("post_rst_out", out_bus, lane(1, 2, 8, 9));
        @(posedge clk);
        #1;
        chk("post_rst_emitted", tag_log.size(), 1);
        if (tag_log.size() > 0) chk("post_rst_only_new", tag_log[0], 8'h77);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
